fetch_unit: RTL

Instruction fetch stage of the GCore accumulator processor. It owns the program counter, fetches 16-bit instruction words from instruction memory over a request/ready handshake, and presents the opcode byte and operand byte to the controller. It accepts the controller's jump/branch decisions together with the datapath's accumulator-zero flag to select the next PC.

---
 rtl/gcore_pkg.sv | 32 +++
 rtl/fetch_unit_pc_next.sv | 27 ++
 rtl/fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/gcore_pkg.sv
// Shared GCore definitions: opcodes, accumulator-source select and the fetch FSM state.
package gcore_pkg;

  // Opcodes live in op[7:4] of the fetched op byte.
  localparam logic [3:0] NOP   = 4'h0;
  localparam logic [3:0] JUMP  = 4'h1;
  localparam logic [3:0] SAVE  = 4'h2;
  localparam logic [3:0] LOAD  = 4'h3;
  localparam logic [3:0] LOADI = 4'h4;
  localparam logic [3:0] SLL   = 4'h5;
  localparam logic [3:0] ADD   = 4'h6;
  localparam logic [3:0] SUB   = 4'h7;
  localparam logic [3:0] AND   = 4'h8;
  localparam logic [3:0] OR    = 4'h9;
  localparam logic [3:0] XOR   = 4'hA;
  localparam logic [3:0] SLT   = 4'hB;
  localparam logic [3:0] BZ    = 4'hC;

  typedef enum logic [1:0] {
    MemtoAcc = 2'd0,
    ImmtoAcc = 2'd1,
    ALUtoAcc = 2'd2,
    SLLtoAcc = 2'd3
  } acc_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select: jump, taken branch-if-zero, or sequential increment.
module pc_next #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] pc,
  input  logic [7:0]    operand,
  input  logic          jump,
  input  logic          branch,
  input  logic          zero,
  output logic [AW-1:0] next_pc
);

  logic [AW-1:0] target;

  // Narrow PCs drop the upper operand bits; wide PCs zero-extend the operand.
  generate
    if (AW <= 8) begin : g_narrow
      assign target = operand[AW-1:0];
    end else begin : g_wide
      assign target = {{(AW-8){1'b0}}, operand};
    end
  endgenerate

  assign next_pc = (jump || (branch && zero)) ? target
                                              : pc + {{(AW-1){1'b0}}, 1'b1};

endmodule

// File: rtl/fetch_unit.sv
// GCore instruction fetch: owns the PC, fetches over req/rdy and holds the issued instruction.
module fetch_unit
  import gcore_pkg::*;
#(
  parameter int          AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rdy,
  input  logic [15:0]   imem_rdata,
  output logic [7:0]    op_o,
  output logic [7:0]    operand_o,
  output logic          valid_o,
  input  logic          stall_i,
  input  logic          jump_i,
  input  logic          branch_i,
  input  logic          acc_zero_i,
  output logic [15:0]   instr_count
);

  fetch_state_t  state_reg;
  logic [AW-1:0] pc_reg;
  logic [AW-1:0] pc_next_val;
  logic          req_reg;
  logic [7:0]    op_reg;
  logic [7:0]    operand_reg;
  logic          valid_reg;
  logic [15:0]   count_reg;

  pc_next #(.AW(AW)) u_pc_next (
    .pc      (pc_reg),
    .operand (operand_reg),
    .jump    (jump_i),
    .branch  (branch_i),
    .zero    (acc_zero_i),
    .next_pc (pc_next_val)
  );

  // Request and address come straight from registers, never from inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pc_reg      <= RESET_PC;
      req_reg     <= 1'b0;
      op_reg      <= 8'h00;
      operand_reg <= 8'h00;
      valid_reg   <= 1'b0;
      count_reg   <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= REQ;
          req_reg   <= 1'b1;
        end
        REQ: begin
          if (imem_rdy) begin
            op_reg      <= imem_rdata[15:8];
            operand_reg <= imem_rdata[7:0];
            valid_reg   <= 1'b1;
            req_reg     <= 1'b0;
            state_reg   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall_i) begin
            count_reg <= count_reg + 16'd1;
            pc_reg    <= pc_next_val;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= REQ;
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign op_o        = op_reg;
  assign operand_o   = operand_reg;
  assign valid_o     = valid_reg;
  assign instr_count = count_reg;

endmodule
